// File: rtl/div113_mw_seq_if.sv
// Stream bundle for the multi-word divide-by-113 engine: dividend words in, quotient words out.
interface div113_mw_seq_if #(
    parameter int unsigned CNT_W = 16
);
    logic             s_valid;
    logic             s_ready;
    logic [52:0]      s_data;
    logic             s_first;
    logic             s_last;
    logic             m_valid;
    logic             m_ready;
    logic [52:0]      m_quot;
    logic             m_last;
    logic [6:0]       m_rem;
    logic [CNT_W-1:0] m_idx;

    // Upstream source / downstream sink side
    modport master (
        output s_valid, s_data, s_first, s_last, m_ready,
        input  s_ready, m_valid, m_quot, m_last, m_rem, m_idx
    );

    // Divider engine side
    modport slave (
        input  s_valid, s_data, s_first, s_last, m_ready,
        output s_ready, m_valid, m_quot, m_last, m_rem, m_idx
    );
endinterface

// File: rtl/div113_mw_seq.sv
// Streams an unsigned dividend MSW-first in 53-bit words, emits one quotient word per input word
// and the final remainder; carried remainder feeds a 60-by-113 combinational divider each cycle.
module div113_mw_seq #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    div113_mw_seq_if.slave   bus,
    output logic [CNT_W-1:0] frames_done,
    output logic             err_nofirst
);
    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [6:0]       rem_q, rem_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             m_valid_q, m_valid_d;
    logic [52:0]      quot_q, quot_d;
    logic             last_q, last_d;
    logic [6:0]       mrem_q, mrem_d;
    logic [CNT_W-1:0] midx_q, midx_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic             err_q, err_d;

    logic             accept;
    logic             start;
    logic [6:0]       r_in;
    logic [59:0]      x;
    logic [59:0]      q_full;
    logic [6:0]       r;
    logic [CNT_W-1:0] idx_next;

    // Single-stage output buffer: a new word may enter whenever the buffer is empty or draining.
    assign bus.s_ready = !m_valid_q || bus.m_ready;
    assign accept      = bus.s_valid && bus.s_ready;

    // A word opens a new frame when flagged first or when no frame is open.
    assign start    = bus.s_first || (state_q == StIdle);
    assign r_in     = start ? 7'd0 : rem_q;
    assign x        = {r_in, bus.s_data};
    assign q_full   = x / 60'd113;
    assign r        = 7'(x % 60'd113);
    assign idx_next = start ? '0 : idx_q;

    // r_in < 113 keeps the quotient within 53 bits.
    a_quot_fits : assert property (@(posedge clk) disable iff (!rst_n)
        accept |-> (q_full[59:53] == 7'd0));

    // Next-state: frame tracking, remainder carry and output buffer load/drain.
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        idx_d     = idx_q;
        m_valid_d = m_valid_q;
        quot_d    = quot_q;
        last_d    = last_q;
        mrem_d    = mrem_q;
        midx_d    = midx_q;
        frames_d  = frames_q;
        err_d     = err_q;
        if (accept) begin
            quot_d    = q_full[52:0];
            last_d    = bus.s_last;
            midx_d    = idx_next;
            idx_d     = idx_next + CNT_W'(1);
            rem_d     = r;
            mrem_d    = bus.s_last ? r : 7'd0;
            m_valid_d = 1'b1;
            if (state_q == StIdle && !bus.s_first) begin
                err_d = 1'b1;
            end
            if (bus.s_last) begin
                state_d  = StIdle;
                frames_d = frames_q + CNT_W'(1);
            end else begin
                state_d = StBusy;
            end
        end else if (bus.m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // State and output registers; reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            idx_q     <= '0;
            m_valid_q <= 1'b0;
            quot_q    <= '0;
            last_q    <= 1'b0;
            mrem_q    <= '0;
            midx_q    <= '0;
            frames_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            quot_q    <= quot_d;
            last_q    <= last_d;
            mrem_q    <= mrem_d;
            midx_q    <= midx_d;
            frames_q  <= frames_d;
            err_q     <= err_d;
        end
    end

    assign bus.m_valid = m_valid_q;
    assign bus.m_quot  = quot_q;
    assign bus.m_last  = last_q;
    // Remainder is only presented alongside a valid word.
    assign bus.m_rem   = m_valid_q ? mrem_q : 7'd0;
    assign bus.m_idx   = midx_q;
    assign frames_done = frames_q;
    assign err_nofirst = err_q;
endmodule

// File: tb/tb_div113_mw_seq.sv
// Self-checking bench for div113_mw_seq: constant vectors, directed corner sequences and a
// randomized run against an arithmetic reference model.
module tb_div113_mw_seq;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] frames_done;
    logic             err_nofirst;

    div113_mw_seq_if #(.CNT_W(CNT_W)) bus ();

    div113_mw_seq #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .frames_done (frames_done),
        .err_nofirst (err_nofirst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic             mv;
    logic [52:0]      mquot;
    logic             mlast;
    logic [6:0]       mrem;
    logic [CNT_W-1:0] midx;
    logic             busy;
    logic [6:0]       rem;
    logic [CNT_W-1:0] idx;
    logic [CNT_W-1:0] frames;
    logic             err;

    typedef struct {
        logic        sf;
        logic        sl;
        logic [52:0] data;
        logic [52:0] quot;
        logic [6:0]  rm;
        logic        last;
        int          ix;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mv = 0; mquot = '0; mlast = 0; mrem = '0; midx = '0;
        busy = 0; rem = '0; idx = '0; frames = '0; err = 0;
    endtask

    // Long division step: the frame's running remainder times 2^53 plus the new word.
    task automatic model_accept(input logic [52:0] d, input logic sf, input logic sl);
        logic        first;
        logic [63:0] xv;
        logic [63:0] qv;
        logic [63:0] rv;
        first = sf || !busy;
        if (!busy && !sf) err = 1;
        xv = (first ? 64'd0 : 64'(rem)) * 64'h0020_0000_0000_0000 + 64'(d);
        qv = xv / 64'd113;
        rv = xv % 64'd113;
        mquot = qv[52:0];
        mlast = sl;
        midx  = first ? '0 : idx;
        idx   = midx + 1'b1;
        rem   = rv[6:0];
        mrem  = sl ? rv[6:0] : 7'd0;
        mv    = 1;
        busy  = !sl;
        if (sl) frames = frames + 1'b1;
    endtask

    task automatic check_outputs();
        chk("m_valid", 64'(bus.m_valid), 64'(mv));
        chk("m_quot", 64'(bus.m_quot), 64'(mquot));
        chk("m_last", 64'(bus.m_last), 64'(mlast));
        chk("m_rem", 64'(bus.m_rem), mv ? 64'(mrem) : 64'd0);
        chk("m_idx", 64'(bus.m_idx), 64'(midx));
        chk("frames_done", 64'(frames_done), 64'(frames));
        chk("err_nofirst", 64'(err_nofirst), 64'(err));
    endtask

    // Called at posedge+1; drives one cycle, checks s_ready, then outputs after the edge.
    task automatic drive_cycle(input logic sv, input logic [52:0] sd, input logic sf,
                               input logic sl, input logic mr);
        logic exp_rdy;
        logic acc;
        bus.s_valid = sv;
        bus.s_data  = sd;
        bus.s_first = sf;
        bus.s_last  = sl;
        bus.m_ready = mr;
        #1;
        exp_rdy = !mv || mr;
        chk("s_ready", 64'(bus.s_ready), 64'(exp_rdy));
        acc = sv && exp_rdy;
        @(posedge clk);
        if (acc) model_accept(sd, sf, sl);
        else if (mr) mv = 0;
        #1;
        check_outputs();
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = '{sf: 1, sl: 1, data: 53'd113, quot: 53'd1, rm: 7'd0, last: 1, ix: 0};
        vecs[1] = '{sf: 1, sl: 1, data: 53'h1F_FFFF_FFFF_FFFF, quot: 53'd79709727918061,
                    rm: 7'd98, last: 1, ix: 0};
        vecs[2] = '{sf: 1, sl: 0, data: 53'd1, quot: 53'd0, rm: 7'd0, last: 0, ix: 0};
        vecs[3] = '{sf: 0, sl: 1, data: 53'd0, quot: 53'd79709727918061, rm: 7'd99, last: 1,
                    ix: 1};
        vecs[4] = '{sf: 1, sl: 1, data: 53'd226, quot: 53'd2, rm: 7'd0, last: 1, ix: 0};

        bus.s_valid = 0; bus.s_data = '0; bus.s_first = 0; bus.s_last = 0; bus.m_ready = 1;
        rst_n = 0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs();
        chk("s_ready_reset", 64'(bus.s_ready), 64'd1);
        rst_n = 1;
        @(posedge clk);
        #1;

        // Constant vectors, back-to-back with m_ready high
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, vecs[i].data, vecs[i].sf, vecs[i].sl, 1);
            chk($sformatf("vec%0d_quot", i), 64'(bus.m_quot), 64'(vecs[i].quot));
            chk($sformatf("vec%0d_rem", i), 64'(bus.m_rem), 64'(vecs[i].rm));
            chk($sformatf("vec%0d_last", i), 64'(bus.m_last), 64'(vecs[i].last));
            chk($sformatf("vec%0d_idx", i), 64'(bus.m_idx), 64'(vecs[i].ix));
            chk($sformatf("vec%0d_valid", i), 64'(bus.m_valid), 64'd1);
        end
        chk("frames_after_vecs", 64'(frames_done), 64'd4);
        drive_cycle(0, '0, 0, 0, 1);

        // Backpressure: one word loaded, then five stalled cycles, then release
        drive_cycle(1, 53'd1000, 1, 0, 0);
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1, 53'd2000, 0, 1, 0);
            chk("stall_quot", 64'(bus.m_quot), 64'd8);
        end
        drive_cycle(1, 53'd2000, 0, 1, 1);
        chk("bp_release_idx", 64'(bus.m_idx), 64'd1);
        drive_cycle(0, '0, 0, 0, 1);

        // Restart mid-frame, then a word without s_first while idle
        drive_cycle(1, 53'd5, 1, 0, 1);
        drive_cycle(1, 53'd113, 1, 1, 1);
        chk("restart_quot", 64'(bus.m_quot), 64'd1);
        chk("restart_idx", 64'(bus.m_idx), 64'd0);
        chk("restart_err", 64'(err_nofirst), 64'd0);
        drive_cycle(1, 53'd113, 0, 1, 1);
        chk("nofirst_err", 64'(err_nofirst), 64'd1);
        chk("nofirst_quot", 64'(bus.m_quot), 64'd1);

        // Asynchronous reset mid-frame
        drive_cycle(1, 53'd77, 1, 0, 1);
        #2;
        rst_n = 0;
        #1;
        model_reset();
        check_outputs();
        chk("s_ready_async_rst", 64'(bus.s_ready), 64'd1);
        #1;
        rst_n = 1;
        drive_cycle(1, 53'd226, 1, 1, 1);
        chk("post_rst_quot", 64'(bus.m_quot), 64'd2);
        chk("post_rst_rem", 64'(bus.m_rem), 64'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [52:0] d;
            d = {21'($urandom), $urandom};
            if ($urandom_range(0, 3) == 0) d = 53'h1F_FFFF_FFFF_FFFF - 53'($urandom_range(0, 3));
            drive_cycle(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 5) == 0),
                        1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/div113_mw_seq.md
# div113_mw_seq

Sequential multi-word divide-by-113 engine. It streams an arbitrarily long unsigned dividend in 53-bit words, most significant word first, and returns one 53-bit quotient word per input word plus the final 7-bit remainder. Each cycle it concatenates the carried remainder with the incoming word into the 60-bit operand of the combinational 60-by-113 divider core, then registers the quotient and remainder. It sits upstream of the divider core and feeds it; downstream consumers see a valid/ready quotient stream.

## Interface
- `CNT_W`, default 16: width of the word index and frame counters.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: input word valid.
- `s_ready` out 1: input word accepted when `s_valid && s_ready`.
- `s_data` in 53: dividend word, bit 52 is the MSB.
- `s_first` in 1: word is the most significant word of a new frame.
- `s_last` in 1: word is the least significant word of the frame.
- `m_valid` out 1: quotient word valid.
- `m_ready` in 1: downstream accepts the quotient word.
- `m_quot` out 53: quotient word.
- `m_last` out 1: quotient word is the last of its frame.
- `m_rem` out 7: final remainder. Meaningful only when `m_valid && m_last`; 0 otherwise.
- `m_idx` out CNT_W: index of the word within its frame, 0 = MSW.
- `frames_done` out CNT_W: count of completed frames, wraps modulo 2^CNT_W.
- `err_nofirst` out 1: sticky. Set when a word is accepted while idle without `s_first`. Cleared only by reset.

## Operation
- State: `IDLE` (no open frame) and `BUSY` (frame open, carried remainder `rem_q` live).
- Handshake: `s_ready = !m_valid || m_ready`. This gives single-stage output buffering and full throughput of one word per cycle when `m_ready` is held high.
- On accept:
  - Operand `X = {r_in, s_data}` (60 bits).
  - `r_in = 0` if `s_first`, else `rem_q`.
  - Divider core yields `q = X / 113` and `r = X mod 113`.
  - Because `r_in < 113`, `X < 113·2^53`, so `q` fits in 53 bits. Any nonzero upper core quotient bit is an RTL bug; assert it in simulation.
- Registered on accept:
  - `m_quot <= q[52:0]`
  - `m_last <= s_last`
  - `m_idx <= s_first ? 0 : idx_q`
  - `rem_q <= r`
  - `m_rem <= s_last ? r : 0`
  - `m_valid <= 1`
- Next-state rules on accept:
  - If `s_last`: state goes to `IDLE`, `frames_done` increments on the same edge.
  - Otherwise: state goes to `BUSY`.
  - `idx_q <= m_idx_next + 1`.
- `m_valid` clears when `m_ready` is high and no new word is accepted.
- `s_first` while `BUSY`: the current frame is abandoned without error and a new frame starts with `r_in = 0`.
- `s_first && s_last`: single-word frame; both rules apply.
- Word accepted in `IDLE` without `s_first`: treated as a first word (`r_in = 0`), and `err_nofirst` is set.
- `idx_q` wraps modulo 2^CNT_W; no error is raised.
- While `m_valid && !m_ready`, all `m_*` outputs hold stable.

## Timing
- Reset values (asynchronous assertion, synchronous-safe release):
  - `m_valid = 0`, `m_quot = 0`, `m_last = 0`, `m_rem = 0`, `m_idx = 0`
  - `frames_done = 0`, `err_nofirst = 0`, `rem_q = 0`
  - state = `IDLE`
  - `s_ready = 1` (combinational from `m_valid`)
- Latency: a word accepted on edge n appears on `m_*` after edge n, and is visible in cycle n+1.
- Throughput: one word per cycle with `m_ready = 1`. An output stall stops input on the same cycle because `s_ready` is combinational from `m_ready`.
- Critical path: `rem_q` → core → `rem_q`. This is a single-cycle loop by design; no retiming across it.
- Reset mid-frame: the frame is lost, the output is discarded, and no partial remainder survives.

## Test plan
- Single word `s_first = s_last = 1`, `s_data = 113` → `m_quot = 1`, `m_rem = 0`, `m_last = 1`, `m_idx = 0`, `frames_done = 1`.
- Single word `s_data = 2^53 − 1` → `m_quot = 79709727918061`, `m_rem = 98`.
- Two-word frame, words 1 then 0 (dividend 2^53), back-to-back with `m_ready = 1`:
  - Outputs `m_quot = 0` (idx 0, `m_last = 0`), then `m_quot = 79709727918061`, `m_rem = 99` (idx 1, `m_last = 1`).
  - Two consecutive valid cycles.
- Backpressure: hold `m_ready = 0` for 5 cycles with `s_valid = 1`.
  - `s_ready = 0`, and `m_*` stay stable throughout.
  - When `m_ready` rises, the next word is accepted that cycle with no loss or duplication.
- Restart and error:
  - `s_first` asserted on the 2nd word of an open frame → `r_in = 0`, `m_idx = 0`, `err_nofirst` stays 0.
  - Then a word without `s_first` in `IDLE` → `err_nofirst = 1`, result equal to the single-word quotient.
- Assert `rst_n = 0` mid-frame (asynchronous, between edges) → all outputs reach reset values immediately. A subsequent frame `s_data = 226` gives `m_quot = 2`, `m_rem = 0`.
